// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Optional macro MDU_DIV_ZERO_FAST_EN adds a single-cycle divide-by-zero path.
module mdu_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 div_by_zero_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ON      = 2'd1,
`ifdef MDU_DIV_ZERO_FAST_EN
        S_DIVZERO = 2'd3,
`endif
        S_END     = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dvd_q;   // dividend magnitude, shifted out as quotient bits shift in
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   rem;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic [WIDTH:0]     r_sh;
    logic               ge;
    logic [WIDTH-1:0]   r_nxt;
    logic [WIDTH-1:0]   q_nxt;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] r,
                                               input logic nq, input logic nr);
        return {(nr ? neg(r) : r), (nq ? neg(q) : q)};
    endfunction

    // r < divisor always holds, so the W-bit wrapped difference is exact when ge is set
    always_comb begin
        r_sh  = {rem, dvd_q[WIDTH-1]};
        ge    = (r_sh >= {1'b0, dvs});
        r_nxt = ge ? (r_sh[WIDTH-1:0] - dvs) : r_sh[WIDTH-1:0];
        q_nxt = {dvd_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            dvd_q         <= '0;
            dvs           <= '0;
            rem           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            result_o      <= '0;
            ready_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            busy_o        <= 1'b0;
        end else if (state != S_IDLE && (annul_i || (state == S_END && !start_i))) begin
            state         <= S_IDLE;
            result_o      <= '0;
            ready_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        dvd_q  <= mag(opdata1_i, signed_div_i);
                        dvs    <= mag(opdata2_i, signed_div_i);
                        neg_q  <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r  <= signed_div_i && opdata1_i[WIDTH-1];
                        dz     <= (opdata2_i == '0);
                        rem    <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
`ifdef MDU_DIV_ZERO_FAST_EN
                        state  <= (opdata2_i == '0) ? S_DIVZERO : S_ON;
`else
                        state  <= S_ON;
`endif
                    end
                end
                S_ON: begin
                    rem   <= r_nxt;
                    dvd_q <= q_nxt;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result_o      <= fix(q_nxt, r_nxt, neg_q, neg_r);
                        ready_o       <= 1'b1;
                        div_by_zero_o <= dz;
                        state         <= S_END;
                    end
                end
`ifdef MDU_DIV_ZERO_FAST_EN
                S_DIVZERO: begin
                    // Same values the restoring loop produces for a zero divisor
                    result_o      <= fix('1, dvd_q, neg_q, neg_r);
                    ready_o       <= 1'b1;
                    div_by_zero_o <= 1'b1;
                    state         <= S_END;
                end
`endif
                S_END: begin
                    state <= S_END;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider (WIDTH=32): driver pushes expectations, monitor checks on ready_o.
module tb_mdu_divider;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           div_by_zero_o;
    logic           busy_o;

    mdu_divider #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .annul_i       (annul_i),
        .signed_div_i  (signed_div_i),
        .opdata1_i     (opdata1_i),
        .opdata2_i     (opdata2_i),
        .result_o      (result_o),
        .ready_o       (ready_o),
        .div_by_zero_o (div_by_zero_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] res;
        logic           dz;
        int             acc;
        int             lat;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic have_cur = 1'b0;
    logic rdy_prev = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on each rising ready_o, then checks the result stays stable while held
    always @(negedge clk) begin
        if (!rst) begin
            rdy_prev = 1'b0;
            have_cur = 1'b0;
        end else begin
            if (ready_o && !rdy_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_ready", {63'd0, ready_o}, '0);
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    chk("result", result_o, cur.res);
                    chk("div_by_zero", {63'd0, div_by_zero_o}, {63'd0, cur.dz});
                    chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                end
            end else if (ready_o && have_cur) begin
                chk("result_stable", result_o, cur.res);
            end
            rdy_prev = ready_o;
        end
    end

    // Called at a negedge: drives a request and records which edge will accept it
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] exp_q, input logic [W-1:0] exp_r, input logic dz);
        exp_t e;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        e.res = {exp_r, exp_q};
        e.dz  = dz;
        e.acc = cyc + 1;
`ifdef MDU_DIV_ZERO_FAST_EN
        e.lat = dz ? 1 : W;
`else
        e.lat = W;
`endif
        q.push_back(e);
    endtask

    task automatic finish_op(input int hold);
        int n;
        @(negedge clk);
        chk("busy_after_accept", {63'd0, busy_o}, 64'd1);
        n = 0;
        while (!ready_o && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {63'd0, ready_o}, 64'd1);
        repeat (hold) @(negedge clk);
        start_i   = 1'b0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        @(negedge clk);
        chk("ready_cleared", {63'd0, ready_o}, '0);
        chk("result_cleared", result_o, '0);
        chk("dz_cleared", {63'd0, div_by_zero_o}, '0);
        chk("busy_cleared", {63'd0, busy_o}, '0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                         input logic dz, input int hold);
        @(negedge clk);
        issue(a, b, sgn, exp_q, exp_r, dz);
        finish_op(hold);
    endtask

    initial begin
        int acc;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result_o, '0);
        chk("reset_ready", {63'd0, ready_o}, '0);
        chk("reset_dz", {63'd0, div_by_zero_o}, '0);
        chk("reset_busy", {63'd0, busy_o}, '0);
        rst = 1'b1;

        do_op(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 5);
        do_op(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0);
        do_op(32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0, 0);
        do_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1);
        do_op(32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 2);
        do_op(32'hFFFF_FFFB,  32'd0,          1'b1, 32'd1,          32'hFFFF_FFFB,  1'b1, 0);
        do_op(32'd7,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd7,          1'b1, 0);
        do_op(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 0);
        do_op(32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 0);

        // Annul: request accepted at E0, annul sampled at E11, never delivers
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
        acc = cyc + 1;
        while (cyc < acc + 10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_busy", {63'd0, busy_o}, '0);
        chk("annul_ready", {63'd0, ready_o}, '0);
        chk("annul_result", result_o, '0);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        do_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 0);

        // Reset mid-operation at E15, then restart with start_i still high
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        acc = cyc + 1;
        while (cyc < acc + 14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_result", result_o, '0);
        chk("rst_mid_ready", {63'd0, ready_o}, '0);
        chk("rst_mid_dz", {63'd0, div_by_zero_o}, '0);
        chk("rst_mid_busy", {63'd0, busy_o}, '0);
        rst = 1'b1;
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        finish_op(0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
